// File: rtl/loopback_pkg.sv
// Shared definitions for the board loopback tester.
//   state_t        : tester FSM states
//   PAT_COUNTER/PAT_LFSR : pattern select encodings
//   LFSR_SEED/LFSR_TAPS  : generator seed and Galois tap mask for x^8+x^6+x^5+x^4+1
//   next_pattern() : one generator step for either pattern mode
package loopback_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    CHECK,
    DONE,
    FAIL
  } state_t;

  localparam int PAT_W = 8;

  localparam logic PAT_COUNTER = 1'b0;
  localparam logic PAT_LFSR    = 1'b1;

  localparam logic [PAT_W-1:0] LFSR_SEED = 8'h01;
  // x^6 + x^5 + x^4 + 1 terms of the polynomial; x^8 is the shifted-out bit.
  localparam logic [PAT_W-1:0] LFSR_TAPS = 8'h71;

  // Galois form: shift left, fold the tap mask back in when the MSB falls out.
  // The map is invertible, so a nonzero seed never reaches 0x00.
  function automatic logic [PAT_W-1:0] next_pattern(input logic [PAT_W-1:0] cur,
                                                    input logic             mode);
    logic [PAT_W-1:0] shifted;
    shifted = {cur[PAT_W-2:0], 1'b0};
    if (mode == PAT_LFSR) begin
      next_pattern = cur[PAT_W-1] ? (shifted ^ LFSR_TAPS) : shifted;
    end else begin
      next_pattern = cur + 1'b1;
    end
  endfunction

endpackage

// File: rtl/loopback_tester_if.sv
// Control/status and loopback data bundle of the loopback tester.
//   start, stop, pat_sel : test control (pulses / mode select)
//   tx_data, rx_data     : byte driven into and returned from the loopback path
//   busy, locked, fail   : test status
//   lat_out, err_count   : discovered latency and saturating mismatch count
// Modports: slave = tester side, master = controller / board side.
interface loopback_tester_if #(
  parameter int DATA_W    = 8,
  parameter int LAT_W     = 4,
  parameter int ERR_CNT_W = 16
) ();

  logic                 start;
  logic                 stop;
  logic                 pat_sel;
  logic [DATA_W-1:0]    tx_data;
  logic [DATA_W-1:0]    rx_data;
  logic                 busy;
  logic                 locked;
  logic                 fail;
  logic [LAT_W-1:0]     lat_out;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  start, stop, pat_sel, rx_data,
    output tx_data, busy, locked, fail, lat_out, err_count
  );

  modport master (
    output start, stop, pat_sel, rx_data,
    input  tx_data, busy, locked, fail, lat_out, err_count
  );

endinterface

// File: rtl/loopback_pattern_gen.sv
// Pattern generator for the loopback tester.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load the seed and capture pat_sel as the mode
//   advance    : step the pattern once
//   pat_sel    : pattern mode, sampled only on load
//   value      : current pattern byte; forced to 0 when neither load nor advance
module loopback_pattern_gen
  import loopback_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic             pat_sel,
  output logic [PAT_W-1:0] value
);

  logic mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      mode  <= PAT_COUNTER;
    end else if (load) begin
      value <= LFSR_SEED;
      mode  <= pat_sel;
    end else if (advance) begin
      value <= next_pattern(value, mode);
    end else begin
      value <= '0;
    end
  end

endmodule

// File: rtl/loopback_tester.sv
// Far end of the board loopback path: drives a byte pattern, finds the
// round-trip latency by matching returned bytes against a history of sent
// bytes, then counts mismatches at that latency until stopped.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : loopback_tester_if.slave (control, status, tx/rx bytes)
// The LFSR pattern is defined for DATA_W = 8.
module loopback_tester
  import loopback_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int MAX_LAT        = 15,
  parameter int LAT_W          = 4,
  parameter int LOCK_RUN       = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int ERR_CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  loopback_tester_if.slave bus
);

  localparam int RUN_W = $clog2(LOCK_RUN + 1);
  localparam int TMO_W = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;

  state_t               state, state_nxt;
  logic [DATA_W-1:0]    tx_data;
  logic [DATA_W-1:0]    hist_q [1:MAX_LAT];
  logic [MAX_LAT:1]     hist_vld;
  logic [LAT_W-1:0]     cand, cand_nxt;
  logic [LAT_W-1:0]     lat_q, lat_nxt;
  logic [LAT_W-1:0]     sel;
  logic [RUN_W-1:0]     run, run_nxt;
  logic [TMO_W-1:0]     tmo, tmo_nxt;
  logic [ERR_CNT_W-1:0] err_q, err_nxt;
  logic                 locked_q, locked_nxt;
  logic                 fail_q, fail_nxt;
  logic                 busy_q;
  logic                 gen_load, gen_adv, hist_clr;
  logic                 in_test;
  logic                 sel_vld, hit;
  logic [DATA_W-1:0]    sel_byte;

  loopback_pattern_gen u_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gen_load),
    .advance (gen_adv),
    .pat_sel (bus.pat_sel),
    .value   (tx_data)
  );

  assign in_test = (state == SEARCH) || (state == CHECK);

  // History stage: hist[0] is the live tx byte, hist[k] is the byte sent k cycles ago.
  always_ff @(posedge clk) begin
    hist_q[1] <= tx_data;
    for (int k = 2; k <= MAX_LAT; k++) begin
      hist_q[k] <= hist_q[k-1];
    end
  end

  // A byte is valid only if it was sent during the current test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_vld <= '0;
    end else if (hist_clr) begin
      hist_vld <= '0;
    end else begin
      hist_vld <= {hist_vld[MAX_LAT-1:1], in_test};
    end
  end

  // Compare stage: SEARCH probes the candidate latency, CHECK uses the locked one.
  always_comb begin
    sel      = (state == CHECK) ? lat_q : cand;
    sel_byte = tx_data;
    sel_vld  = in_test;
    if (sel != '0) begin
      sel_byte = hist_q[sel];
      sel_vld  = hist_vld[sel];
    end
    hit = sel_vld && (bus.rx_data == sel_byte);
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    run_nxt    = run;
    tmo_nxt    = tmo;
    lat_nxt    = lat_q;
    locked_nxt = locked_q;
    fail_nxt   = fail_q;
    err_nxt    = err_q;
    gen_load   = 1'b0;
    gen_adv    = 1'b0;
    hist_clr   = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (bus.start) begin
          state_nxt  = SEARCH;
          cand_nxt   = '0;
          run_nxt    = '0;
          tmo_nxt    = '0;
          lat_nxt    = '0;
          locked_nxt = 1'b0;
          fail_nxt   = 1'b0;
          err_nxt    = '0;
          gen_load   = 1'b1;
          hist_clr   = 1'b1;
        end
      end
      SEARCH: begin
        gen_adv = 1'b1;
        tmo_nxt = tmo + 1'b1;
        if (bus.stop) begin
          state_nxt  = IDLE;
          locked_nxt = 1'b0;
          fail_nxt   = 1'b0;
          gen_adv    = 1'b0;
        end else if (hit && (run == RUN_W'(LOCK_RUN - 1))) begin
          state_nxt  = CHECK;
          lat_nxt    = cand;
          locked_nxt = 1'b1;
        end else if (tmo == TMO_W'(SEARCH_TIMEOUT - 1)) begin
          state_nxt = FAIL;
          fail_nxt  = 1'b1;
          gen_adv   = 1'b0;
        end else if (hit) begin
          run_nxt = run + 1'b1;
        end else begin
          run_nxt  = '0;
          cand_nxt = (cand == LAT_W'(MAX_LAT)) ? '0 : cand + 1'b1;
        end
      end
      CHECK: begin
        gen_adv = 1'b1;
        // The stop-cycle comparison still counts.
        if (!hit && (err_q != '1)) begin
          err_nxt = err_q + 1'b1;
        end
        if (bus.stop) begin
          state_nxt = DONE;
          gen_adv   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cand     <= '0;
      run      <= '0;
      tmo      <= '0;
      lat_q    <= '0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      run      <= run_nxt;
      tmo      <= tmo_nxt;
      lat_q    <= lat_nxt;
      locked_q <= locked_nxt;
      fail_q   <= fail_nxt;
      err_q    <= err_nxt;
      busy_q   <= (state_nxt == SEARCH) || (state_nxt == CHECK);
    end
  end

  assign bus.tx_data   = tx_data;
  assign bus.busy      = busy_q;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;
  assign bus.lat_out   = lat_q;
  assign bus.err_count = err_q;

endmodule
